// File: rtl/universal_rotate_pkg.sv
// ----------------------------------------------------------------------------
// universal_rotate_pkg
// Shared constants and types for the universal rotate/shift register:
//   - step mode encodings (rotate, logical shift, arithmetic shift, hold)
//   - direction encodings (left, right)
//   - burst controller state type
// ----------------------------------------------------------------------------
package universal_rotate_pkg;

    localparam logic [1:0] MODE_ROT  = 2'b00;
    localparam logic [1:0] MODE_LSH  = 2'b01;
    localparam logic [1:0] MODE_ASH  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/rotate_shift_unit.sv
// ----------------------------------------------------------------------------
// rotate_shift_unit
// Purely combinational single-step function of the register.
// Ports:
//   q      in  DW  current register value
//   dir    in  1   0 = left, 1 = right
//   mode   in  2   rotate / logical shift / arithmetic shift / hold
//   amt    in  AW  bit positions to move
//   q_next out DW  value after one step
// ----------------------------------------------------------------------------
module rotate_shift_unit
    import universal_rotate_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = $clog2(DW)
) (
    input  logic [DW-1:0] q,
    input  logic          dir,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] amt,
    output logic [DW-1:0] q_next
);

    localparam logic [31:0] DW_U = 32'(DW);

    logic [31:0]     amt_w;
    logic [31:0]     rot_amt;
    logic [2*DW-1:0] dbl;

    // For non-power-of-two widths amt can reach or exceed DW, so rotation
    // folds the amount and shifts saturate explicitly.
    assign amt_w   = 32'(amt);
    assign rot_amt = amt_w % DW_U;

    always_comb begin
        dbl    = '0;
        q_next = q;
        if (amt_w != 32'd0) begin
            case (mode)
                MODE_ROT: begin
                    // Shifting a doubled copy leaves the rotated word in one half.
                    if (dir == DIR_L) begin
                        dbl    = {q, q} << rot_amt;
                        q_next = dbl[2*DW-1:DW];
                    end else begin
                        dbl    = {q, q} >> rot_amt;
                        q_next = dbl[DW-1:0];
                    end
                end
                MODE_LSH: begin
                    if (amt_w >= DW_U)     q_next = '0;
                    else if (dir == DIR_L) q_next = q << amt_w;
                    else                   q_next = q >> amt_w;
                end
                MODE_ASH: begin
                    // Arithmetic left is identical to logical left.
                    if (dir == DIR_L) begin
                        if (amt_w >= DW_U) q_next = '0;
                        else               q_next = q << amt_w;
                    end else begin
                        if (amt_w >= DW_U) q_next = {DW{q[DW-1]}};
                        else               q_next = $signed(q) >>> amt_w;
                    end
                end
                default: q_next = q;
            endcase
        end
    end

endmodule

// File: rtl/universal_rotate_reg.sv
// ----------------------------------------------------------------------------
// universal_rotate_reg
// Rotate/shift register with parallel load, single steps and self-timed
// bursts of N steps with a busy/done handshake.
// Ports:
//   clk        in  1   rising-edge clock
//   async_rst  in  1   asynchronous active-high reset
//   load       in  1   parallel load of data (also aborts a burst)
//   en         in  1   single step using live dir/mode/amt (idle only)
//   start      in  1   begin a burst of `steps` steps
//   steps      in  CW  burst length (0 gives a done pulse only)
//   dir        in  1   0 = left, 1 = right
//   mode       in  2   00 rotate, 01 logical, 10 arithmetic, 11 hold
//   amt        in  AW  bit positions per step
//   data       in  DW  parallel load value
//   q          out DW  register contents
//   busy       out 1   burst in progress
//   done       out 1   one-cycle pulse at burst completion
// ----------------------------------------------------------------------------
module universal_rotate_reg
    import universal_rotate_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = $clog2(DW),
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          async_rst,
    input  logic          load,
    input  logic          en,
    input  logic          start,
    input  logic [CW-1:0] steps,
    input  logic          dir,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] q,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [DW-1:0] q_q, q_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          cfg_dir_q, cfg_dir_d;
    logic [1:0]    cfg_mode_q, cfg_mode_d;
    logic [AW-1:0] cfg_amt_q, cfg_amt_d;
    logic          done_q, done_d;

    logic          sel_dir;
    logic [1:0]    sel_mode;
    logic [AW-1:0] sel_amt;
    logic [DW-1:0] step_val;

    // One step unit serves both paths: latched config while running,
    // live inputs while idle.
    assign sel_dir  = (state_q == RUN) ? cfg_dir_q  : dir;
    assign sel_mode = (state_q == RUN) ? cfg_mode_q : mode;
    assign sel_amt  = (state_q == RUN) ? cfg_amt_q  : amt;

    rotate_shift_unit #(
        .DW (DW),
        .AW (AW)
    ) u_step (
        .q      (q_q),
        .dir    (sel_dir),
        .mode   (sel_mode),
        .amt    (sel_amt),
        .q_next (step_val)
    );

    // State register (and all other flops)
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q    <= IDLE;
            q_q        <= '0;
            rem_q      <= '0;
            cfg_dir_q  <= DIR_L;
            cfg_mode_q <= MODE_ROT;
            cfg_amt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            rem_q      <= rem_d;
            cfg_dir_q  <= cfg_dir_d;
            cfg_mode_q <= cfg_mode_d;
            cfg_amt_q  <= cfg_amt_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!load && start && (steps != '0)) state_d = RUN;
            RUN:  if (load || (rem_q == CW'(1)))       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: register value, remaining count, latched config, done
    always_comb begin
        q_d        = q_q;
        rem_d      = rem_q;
        cfg_dir_d  = cfg_dir_q;
        cfg_mode_d = cfg_mode_q;
        cfg_amt_d  = cfg_amt_q;
        done_d     = 1'b0;
        if (state_q == IDLE) begin
            if (load) begin
                q_d = data;
            end else if (start) begin
                if (steps == '0) begin
                    done_d = 1'b1;
                end else begin
                    rem_d      = steps;
                    cfg_dir_d  = dir;
                    cfg_mode_d = mode;
                    cfg_amt_d  = amt;
                end
            end else if (en) begin
                q_d = step_val;
            end
        end else begin
            if (load) begin
                // Abort: no completion pulse.
                q_d   = data;
                rem_d = '0;
            end else begin
                q_d   = step_val;
                rem_d = rem_q - CW'(1);
                if (rem_q == CW'(1)) done_d = 1'b1;
            end
        end
    end

    // Outputs, all decoded from flops only
    always_comb begin
        q    = q_q;
        busy = (state_q == RUN);
        done = done_q;
    end

endmodule

// File: tb/tb_universal_rotate_reg.sv
module tb_universal_rotate_reg;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          async_rst;
    logic          load, en, start, dir;
    logic [CW-1:0] steps;
    logic [1:0]    mode;
    logic [AW-1:0] amt;
    logic [DW-1:0] data;
    logic [DW-1:0] q;
    logic          busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    universal_rotate_reg #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk       (clk),
        .async_rst (async_rst),
        .load      (load),
        .en        (en),
        .start     (start),
        .steps     (steps),
        .dir       (dir),
        .mode      (mode),
        .amt       (amt),
        .data      (data),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Bit-by-bit reference step: each output bit names its source bit.
    function automatic logic [DW-1:0] ref_step(input logic [DW-1:0] v, input logic d,
                                               input logic [1:0] m, input int a);
        logic [DW-1:0] r;
        r = v;
        if (m == 2'b11 || a == 0) return v;
        for (int i = 0; i < DW; i++) begin
            if (m == 2'b00) begin
                if (d == 1'b0) r[i] = v[(i - (a % DW) + DW) % DW];
                else           r[i] = v[(i + a) % DW];
            end else if (d == 1'b0) begin
                r[i] = (i >= a) ? v[i - a] : 1'b0;
            end else begin
                r[i] = (i + a < DW) ? v[i + a] : ((m == 2'b10) ? v[DW-1] : 1'b0);
            end
        end
        return r;
    endfunction

    // Behavioural model
    logic [DW-1:0] m_q;
    logic          m_busy, m_done, m_dir;
    logic [1:0]    m_mode;
    int            m_amt, m_left;

    always @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            m_q <= '0; m_busy <= 0; m_done <= 0; m_left <= 0;
            m_dir <= 0; m_mode <= 0; m_amt <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (load) begin
                    m_q <= data; m_busy <= 1'b0; m_left <= 0;
                end else begin
                    m_q    <= ref_step(m_q, m_dir, m_mode, m_amt);
                    m_left <= m_left - 1;
                    if (m_left == 1) begin m_busy <= 1'b0; m_done <= 1'b1; end
                end
            end else if (load) begin
                m_q <= data;
            end else if (start) begin
                if (steps == 0) m_done <= 1'b1;
                else begin
                    m_busy <= 1'b1; m_left <= int'(steps);
                    m_dir <= dir; m_mode <= mode; m_amt <= int'(amt);
                end
            end else if (en) begin
                m_q <= ref_step(m_q, dir, mode, int'(amt));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic l, input logic e, input logic s, input logic [CW-1:0] st,
                         input logic d, input logic [1:0] m, input logic [AW-1:0] a,
                         input logic [DW-1:0] dt);
        load = l; en = e; start = s; steps = st; dir = d; mode = m; amt = a; data = dt;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 8'd0, 0, 2'b00, 3'd0, 8'h00);
    endtask

    initial begin
        async_rst = 1'b1;
        load = 0; en = 0; start = 0; steps = 0; dir = 0; mode = 0; amt = 0; data = 0;
        fork
            forever begin
                @(negedge clk);
                chk("cyc_q",    32'(q),    32'(m_q));
                chk("cyc_busy", 32'(busy), 32'(m_busy));
                chk("cyc_done", 32'(done), 32'(m_done));
            end
            begin
                @(negedge clk); @(negedge clk);
                chk("rst_q", 32'(q), 32'h0);
                chk("rst_busy", 32'(busy), 32'h0);
                chk("rst_done", 32'(done), 32'h0);
                async_rst = 1'b0;
                idle_cycle();

                // Single steps
                drive(1, 0, 0, 0, 0, 2'b00, 3'd0, 8'hA5);
                drive(0, 1, 0, 0, 0, 2'b00, 3'd1, 8'h00);
                chk("rotl1", 32'(q), 32'h4B);
                drive(1, 0, 0, 0, 0, 2'b00, 3'd0, 8'hA5);
                drive(0, 1, 0, 0, 1, 2'b00, 3'd3, 8'h00);
                chk("rotr3", 32'(q), 32'hB4);
                drive(0, 1, 0, 0, 1, 2'b11, 3'd3, 8'h00);
                chk("hold", 32'(q), 32'hB4);
                drive(0, 1, 0, 0, 0, 2'b00, 3'd0, 8'h00);
                chk("amt0", 32'(q), 32'hB4);

                // Shifts
                drive(1, 0, 0, 0, 0, 2'b00, 3'd0, 8'h90);
                drive(0, 1, 0, 0, 1, 2'b10, 3'd2, 8'h00);
                chk("ashr2", 32'(q), 32'hE4);
                drive(1, 0, 0, 0, 0, 2'b00, 3'd0, 8'h90);
                drive(0, 1, 0, 0, 0, 2'b01, 3'd1, 8'h00);
                chk("lshl1", 32'(q), 32'h20);
                drive(1, 0, 0, 0, 0, 2'b00, 3'd0, 8'h90);
                drive(0, 1, 0, 0, 1, 2'b01, 3'd7, 8'h00);
                chk("lshr7", 32'(q), 32'h01);
                drive(1, 0, 0, 0, 0, 2'b00, 3'd0, 8'h90);
                drive(0, 1, 0, 0, 0, 2'b10, 3'd1, 8'h00);
                chk("ashl1", 32'(q), 32'h20);

                // Burst of 4, live inputs toggled underneath
                drive(1, 0, 0, 0, 0, 2'b00, 3'd0, 8'h81);
                drive(0, 0, 1, 8'd4, 0, 2'b00, 3'd1, 8'h00);
                chk("b_q0", 32'(q), 32'h81);
                chk("b_busy0", 32'(busy), 32'h1);
                drive(0, 1, 1, 8'd2, 1, 2'b11, 3'd5, 8'h00);
                chk("b_q1", 32'(q), 32'h03);
                drive(0, 0, 0, 8'd0, 0, 2'b01, 3'd2, 8'h00);
                chk("b_q2", 32'(q), 32'h06);
                drive(0, 1, 0, 8'd0, 1, 2'b10, 3'd7, 8'h00);
                chk("b_q3", 32'(q), 32'h0C);
                chk("b_busy3", 32'(busy), 32'h1);
                drive(0, 1, 0, 8'd0, 1, 2'b00, 3'd1, 8'h00);
                chk("b_q4", 32'(q), 32'h18);
                chk("b_busy4", 32'(busy), 32'h0);
                chk("b_done", 32'(done), 32'h1);
                idle_cycle();
                chk("b_done_clr", 32'(done), 32'h0);
                chk("b_q_idle", 32'(q), 32'h18);

                // Abort
                drive(1, 0, 0, 0, 0, 2'b00, 3'd0, 8'h81);
                drive(0, 0, 1, 8'd4, 0, 2'b00, 3'd1, 8'h00);
                idle_cycle();
                chk("ab_q1", 32'(q), 32'h03);
                drive(1, 0, 0, 0, 0, 2'b00, 3'd0, 8'h3C);
                chk("ab_q", 32'(q), 32'h3C);
                chk("ab_busy", 32'(busy), 32'h0);
                chk("ab_done", 32'(done), 32'h0);
                idle_cycle();
                chk("ab_done2", 32'(done), 32'h0);

                // Zero-length burst
                drive(0, 0, 1, 8'd0, 0, 2'b00, 3'd1, 8'h00);
                chk("z_done", 32'(done), 32'h1);
                chk("z_busy", 32'(busy), 32'h0);
                chk("z_q", 32'(q), 32'h3C);
                idle_cycle();
                chk("z_done_clr", 32'(done), 32'h0);

                // Back-to-back bursts: restart in the done cycle
                drive(0, 0, 1, 8'd1, 0, 2'b00, 3'd1, 8'h00);
                idle_cycle();
                chk("bb_q1", 32'(q), 32'h78);
                chk("bb_done1", 32'(done), 32'h1);
                drive(0, 0, 1, 8'd2, 0, 2'b00, 3'd1, 8'h00);
                chk("bb_busy", 32'(busy), 32'h1);
                chk("bb_done_gap", 32'(done), 32'h0);
                idle_cycle();
                idle_cycle();
                chk("bb_q2", 32'(q), 32'hE1);
                chk("bb_done2", 32'(done), 32'h1);
                idle_cycle();

                // Priority: load wins over start and en
                drive(1, 1, 1, 8'd3, 0, 2'b00, 3'd1, 8'h5A);
                chk("pri_q", 32'(q), 32'h5A);
                chk("pri_busy", 32'(busy), 32'h0);
                idle_cycle();
                chk("pri_busy2", 32'(busy), 32'h0);

                // Asynchronous reset mid-burst
                drive(0, 0, 1, 8'd5, 0, 2'b00, 3'd1, 8'h00);
                idle_cycle();
                #2 async_rst = 1'b1;
                #1;
                chk("ar_q", 32'(q), 32'h0);
                chk("ar_busy", 32'(busy), 32'h0);
                chk("ar_done", 32'(done), 32'h0);
                @(negedge clk);
                async_rst = 1'b0;
                idle_cycle();
                chk("ar_idle_busy", 32'(busy), 32'h0);
                chk("ar_idle_q", 32'(q), 32'h0);
                idle_cycle();

                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
        join
    end

endmodule

// File: doc/universal_rotate_reg.md
# universal_rotate_reg

Parametrised rotate/shift register with parallel load, bidirectional multi-bit stepping and a self-timed burst mode. A single step applies one rotate or shift of a programmable amount. A burst applies N such steps autonomously and signals completion with a `busy`/`done` handshake. It is the general-purpose successor to the fixed 1-bit left-rotate register and sits in datapaths that need scrambling, bit alignment or serial-style shifting under control-FSM supervision.

## Interface
Parameters:
- `DW`, 8, register width (≥2)
- `AW`, `$clog2(DW)`, width of step amount `amt`
- `CW`, 8, width of burst step count `steps`

Ports:
- `clk`  in  1  rising-edge clock
- `async_rst`  in  1  asynchronous, active-high reset
- `load`  in  1  parallel load of `data`
- `en`  in  1  apply one step (idle only)
- `start`  in  1  begin burst of `steps` steps
- `steps`  in  CW  burst length
- `dir`  in  1  0 = left, 1 = right
- `mode`  in  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 hold
- `amt`  in  AW  bit positions per step
- `data`  in  DW  parallel load value
- `q`  out  DW  register contents
- `busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse at burst completion

## Operation
- Reset values: `q`=0, `busy`=0, `done`=0, FSM=IDLE, remaining count=0.
- Step function (combinational):
  - Rotate: rotate by `amt` mod DW.
  - Logical shift: zero fill. `amt`≥DW gives 0.
  - Arithmetic shift right: fill with `q[DW-1]`. Arithmetic shift left behaves as logical left. `amt`≥DW gives all sign bits (right) or 0 (left).
  - Mode 11 or `amt`=0: `q` unchanged.
- Priority in IDLE: `load` > `start` > `en`.
  - `load`: `q`←`data`.
  - `en`: `q`←step(`q`) using the live `dir`/`mode`/`amt`.
- FSM has two states, IDLE and RUN.
  - IDLE→RUN: on `start` with `steps`≠0. Latches `dir`, `mode`, `amt` and sets remaining←`steps`. `q` is unchanged on this edge.
  - RUN: each edge applies step(`q`) with the latched config and decrements remaining. When remaining goes 1→0: return to IDLE, `busy`←0, `done`←1.
  - `start` with `steps`=0: stay in IDLE, `done`←1 for one cycle, `q` unchanged.
- In RUN:
  - `start` and `en` are ignored.
  - Live `dir`/`mode`/`amt` changes have no effect.
  - `load` aborts the burst: `q`←`data`, go to IDLE, `busy`←0, no `done` pulse.
- `done` is cleared on the cycle after it is set unless re-set by a new completion.
- `async_rst` at any time, including mid-burst, clears all state immediately without waiting for a clock edge.

## Timing
- `load` and `en`: `q` updates at the sampling edge, so new value is visible after that edge. Latency is 1 cycle.
- Burst with `start` sampled at edge k and `steps`=N:
  - `busy` is high from after edge k through edge k+N.
  - Steps are applied at edges k+1 … k+N.
  - `done` is high for the single cycle after edge k+N.
- Back-to-back bursts: `start` may be asserted in the `done` cycle. It is accepted at that edge.
- `busy` and `done` are registered outputs. There is no combinational path from inputs to outputs.

## Structure
- Package `universal_rotate_pkg` holds:
  - mode constants: `MODE_ROT`, `MODE_LSH`, `MODE_ASH`, `MODE_HOLD`
  - direction constants: `DIR_L`, `DIR_R`
  - FSM state type: IDLE, RUN
- Sub-module `rotate_shift_unit` (combinational, parameters `DW`/`AW`):
  - inputs `q`, `dir`, `mode`, `amt`; output next value.
  - instantiated once and shared between single-step and burst paths via a config mux.
- Top level contains the FSM, remaining-step counter, latched configuration and the `q` register.

## Test plan
All scenarios use DW=8.
- Reset: assert `async_rst` at a non-edge time during a burst → `q`=0, `busy`=0, `done`=0 immediately. Deassert → IDLE.
- Single steps: load 8'hA5, then:
  - `en`, rotate left, `amt`=1 → 8'h4B.
  - reload 8'hA5, `en`, rotate right, `amt`=3 → 8'hB4.
  - mode 11 with `en` → unchanged.
- Shifts: load 8'h90, then:
  - arithmetic right, `amt`=2 → 8'hE4.
  - reload 8'h90, logical left, `amt`=1 → 8'h20.
  - reload 8'h90, logical right, `amt`=7 → 8'h01.
- Burst: load 8'h81, `start` with `steps`=4, rotate left, `amt`=1. Toggle `en`/`dir` during the burst.
  - `q` sequence: 03, 06, 0C, 18.
  - `busy` high for 4 cycles, then a single-cycle `done`. Toggled inputs have no effect.
- Abort and zero-length:
  - Mid-burst `load` 8'h3C → `q`=8'h3C, `busy` drops, no `done`.
  - `start` with `steps`=0 → `done` pulse only, `q` unchanged.
- Priority: in IDLE, `load`+`start`+`en` asserted together → `q`=`data`, no burst started.
